// File: rtl/keccak_chi_iota_if.sv
// Handshake and state-memory bus between the chi/iota stage and the round controller.
interface keccak_chi_iota_if #(
  parameter int LANE_WIDTH = 64
);
  logic                  start;
  logic [0:LANE_WIDTH-1] rc;
  logic                  done;
  logic                  busy;
  logic [4:0]            mem_adr;
  logic [0:LANE_WIDTH-1] mem_in;
  logic [0:LANE_WIDTH-1] mem_out;
  logic                  mem_r;
  logic                  mem_w;

  modport master (
    output start, rc, mem_out,
    input  done, busy, mem_adr, mem_in, mem_r, mem_w
  );

  modport slave (
    input  start, rc, mem_out,
    output done, busy, mem_adr, mem_in, mem_r, mem_w
  );
endinterface

// File: rtl/keccak_chi_iota.sv
// Keccak chi + iota step, applied in place to a 25-lane state memory one row at a time.
//
// state   | meaning
// IDLE    | waiting for start; rc captured on accept
// READ    | issue the five lane reads of row y
// CAPTURE | one gap cycle letting the last read land
// WRITE   | write chi (and iota on lane 0) back for row y
// DONE    | step finished; done held while start stays high
module keccak_chi_iota #(
  parameter int LANE_WIDTH = 64,
  parameter bit APPLY_IOTA = 1'b1
) (
  input logic              clock,
  input logic              reset,
  keccak_chi_iota_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  state_t                state_q, state_nxt;
  logic [2:0]            col_q, col_nxt;
  logic [2:0]            y_q, y_nxt;
  logic [0:LANE_WIDTH-1] rc_q, rc_nxt;
  logic [0:LANE_WIDTH-1] row_q [0:4];

  logic                  done_q, done_nxt;
  logic                  busy_q, busy_nxt;
  logic                  mem_r_q, mem_r_nxt;
  logic                  mem_w_q, mem_w_nxt;
  logic [4:0]            mem_adr_q, mem_adr_nxt;
  logic [0:LANE_WIDTH-1] mem_in_q, mem_in_nxt;

  logic                  rd_pend_q;
  logic [2:0]            iss_col_q, cap_col_q;

  logic [2:0]            col_p1, col_p2;
  logic [4:0]            lane_adr;
  logic [0:LANE_WIDTH-1] chi_lane, iota_term;

  assign col_p1    = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
  assign col_p2    = (col_q >= 3'd3) ? col_q - 3'd3 : col_q + 3'd2;
  assign lane_adr  = 5'(y_q) * 5'd5 + 5'(col_q);
  assign chi_lane  = row_q[col_q] ^ (~row_q[col_p1] & row_q[col_p2]);
  assign iota_term = (APPLY_IOTA && y_q == 3'd0 && col_q == 3'd0) ? rc_q : '0;

  always_comb begin
    state_nxt   = state_q;
    col_nxt     = col_q;
    y_nxt       = y_q;
    rc_nxt      = rc_q;
    done_nxt    = 1'b0;
    busy_nxt    = 1'b0;
    mem_r_nxt   = 1'b0;
    mem_w_nxt   = 1'b0;
    mem_adr_nxt = '0;
    mem_in_nxt  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nxt = READ;
          col_nxt   = '0;
          y_nxt     = '0;
          rc_nxt    = bus.rc;
          busy_nxt  = 1'b1;
        end
      end
      READ: begin
        busy_nxt    = 1'b1;
        mem_r_nxt   = 1'b1;
        mem_adr_nxt = lane_adr;
        if (col_q == 3'd4) begin
          state_nxt = CAPTURE;
          col_nxt   = '0;
        end else begin
          col_nxt = col_q + 3'd1;
        end
      end
      CAPTURE: begin
        busy_nxt  = 1'b1;
        state_nxt = WRITE;
        col_nxt   = '0;
      end
      WRITE: begin
        busy_nxt    = 1'b1;
        mem_w_nxt   = 1'b1;
        mem_adr_nxt = lane_adr;
        mem_in_nxt  = chi_lane ^ iota_term;
        if (col_q == 3'd4) begin
          col_nxt = '0;
          if (y_q < 3'd4) begin
            y_nxt     = y_q + 3'd1;
            state_nxt = READ;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          col_nxt = col_q + 3'd1;
        end
      end
      DONE: begin
        // first DONE cycle always pulses done, even if start already fell
        done_nxt = bus.start || !done_q;
        if (!bus.start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      y_q       <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      mem_adr_q <= '0;
      mem_in_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      col_q     <= col_nxt;
      y_q       <= y_nxt;
      done_q    <= done_nxt;
      busy_q    <= busy_nxt;
      mem_r_q   <= mem_r_nxt;
      mem_w_q   <= mem_w_nxt;
      mem_adr_q <= mem_adr_nxt;
      mem_in_q  <= mem_in_nxt;
      rd_pend_q <= mem_r_q;
    end
  end

  // Read data lands one cycle after the registered strobe, so the column tag trails by two.
  always_ff @(posedge clock) begin
    rc_q      <= rc_nxt;
    iss_col_q <= col_q;
    cap_col_q <= iss_col_q;
    if (rd_pend_q) row_q[cap_col_q] <= bus.mem_out;
  end

  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.mem_r   = mem_r_q;
  assign bus.mem_w   = mem_w_q;
  assign bus.mem_adr = mem_adr_q;
  assign bus.mem_in  = mem_in_q;

endmodule
